fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that sits between the PC logic and the instruction ROM/memory port. It owns the fetch PC and issues credit-limited requests over a request/grant port. It buffers in-order responses in a small FIFO tagged with their PC, and presents them to decode over a valid/ready handshake. On a branch redirect it flushes the FIFO and drops all in-flight responses.

---
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; owns the fetch PC, issues credit-limited
//   fetches, buffers in-order responses tagged with their PC, and flushes on redirect.
// Latency: grant at N, rvalid at N+1 (earliest), inst_valid_o at N+2 (registered FIFO).
// Backpressure: mem_req_o drops while in-flight + buffered == DEPTH; decode stalls via inst_ready_i.
// Ports: clk_i/rst_i (async active-low); redirect_i/redirect_pc_i branch redirect;
//   mem_req_o/mem_addr_o/mem_gnt_i request port; mem_rvalid_i/mem_rdata_i response;
//   inst_valid_o/inst_o/inst_pc_o/inst_ready_i decode handshake.
module fetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int             CW   = $clog2(DEPTH + 1);  // counters span 0..DEPTH
  localparam int             PW   = $clog2(DEPTH);      // pointers span 0..DEPTH-1
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_infl;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_qwptr;
  logic [PW-1:0] r_qrptr;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [31:0]   r_q_pc      [DEPTH];  // addresses of in-flight requests, oldest at r_qrptr

  logic [CW:0]   w_used;
  logic          w_credit;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_drop;
  logic          w_wr;
  logic          w_pop;
  logic [CW-1:0] w_infl_nxt;
  logic [1:0]    w_unused_pc_lsb;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit uses registered state only, so the request never depends on gnt/redirect.
  assign w_used     = {1'b0, r_infl} + {1'b0, r_cnt};
  assign w_credit   = w_used < (CW+1)'(DEPTH);
  assign w_gnt      = w_credit & mem_gnt_i;
  // An rvalid with nothing outstanding is a protocol violation and is ignored.
  assign w_rsp      = mem_rvalid_i & (r_infl != '0);
  assign w_drop     = w_rsp & (r_disc != '0);
  // A response in the redirect cycle belongs to the old stream and is never stored.
  assign w_wr       = w_rsp & ~w_drop & ~redirect_i;
  assign w_pop      = (r_cnt != '0) & inst_ready_i;
  assign w_infl_nxt = r_infl + CW'(w_gnt) - CW'(w_rsp);

  assign w_unused_pc_lsb = redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc    <= RESET_PC;
      r_infl  <= '0;
      r_disc  <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_qwptr <= '0;
      r_qrptr <= '0;
    end else begin
      if (w_gnt) begin
        r_pc    <= r_pc + 32'd4;
        r_qwptr <= inc(r_qwptr);
      end
      // The PC queue tracks every outstanding request, including ones to be discarded.
      if (w_rsp) r_qrptr <= inc(r_qrptr);
      r_infl <= w_infl_nxt;
      if (redirect_i) begin
        r_pc   <= {redirect_pc_i[31:2], 2'b00};
        r_disc <= w_infl_nxt;  // everything still outstanding after this edge is stale
        r_cnt  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        r_disc <= r_disc - CW'(w_drop);
        r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_pop);
        if (w_wr)  r_wptr <= inc(r_wptr);
        if (w_pop) r_rptr <= inc(r_rptr);
      end
    end
  end

  // Payload storage needs no reset: validity is carried entirely by the counters.
  always_ff @(posedge clk_i) begin
    if (w_gnt) r_q_pc[r_qwptr] <= r_pc;
    if (w_wr) begin
      r_fifo_pc[r_wptr]   <= r_q_pc[r_qrptr];
      r_fifo_inst[r_wptr] <= mem_rdata_i;
    end
  end

  assign mem_req_o    = w_credit;
  assign mem_addr_o   = r_pc;
  assign inst_valid_o = (r_cnt != '0);
  // Zero the head when empty so reset and flush never expose stale payload.
  assign inst_o       = inst_valid_o ? r_fifo_inst[r_rptr] : '0;
  assign inst_pc_o    = inst_valid_o ? r_fifo_pc[r_rptr]   : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl against an epoch-tagged queue model.
// Latency: the memory model returns each granted request after a per-request latency.
// Backpressure: decode ready and memory grant are driven by directed steps and $urandom.
module tb_fetch_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk_i;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Each outstanding request remembers the redirect epoch it was issued in;
  // a response is delivered only if no redirect happened since its grant.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        mem_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc;
  int          epoch;
  int          cyc;
  int          lat_lo;
  int          lat_hi;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic credit;
    credit = (mem_q.size() + fifo_q.size()) < DEPTH;
    chk("mem_req", 32'(mem_req_o), 32'(credit));
    chk("mem_addr", mem_addr_o, m_pc);
    chk("inst_valid", 32'(inst_valid_o), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) begin
      chk("inst", inst_o, fifo_q[0].inst);
      chk("inst_pc", inst_pc_o, fifo_q[0].pc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    fifo_q.delete();
    m_pc  = RPC;
    epoch = 0;
  endtask

  task automatic drive_idle();
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    inst_ready_i  = 1'b0;
  endtask

  // Reset is asserted and released between clock edges.
  task automatic do_reset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    drive_idle();
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd1);
    chk("rst_mem_addr", mem_addr_o, RPC);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    model_reset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
  endtask

  // One clock: check registered outputs at the falling edge, drive this cycle's
  // inputs, then advance the model to the state expected after the rising edge.
  task automatic cycle(input logic g, input logic r, input logic redir,
                       input logic [31:0] rpc, input logic force_rv);
    logic rsp;
    logic grant;
    req_t e;
    @(negedge clk_i);
    check_outputs();
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    mem_gnt_i     = g;
    inst_ready_i  = r;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    mem_rvalid_i  = rsp || (force_rv && mem_q.size() == 0);
    mem_rdata_i   = rsp ? (mem_q[0].addr ^ KEY) : $urandom();
    grant = ((mem_q.size() + fifo_q.size()) < DEPTH) && g;
    if (r && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (rsp) begin
      e = mem_q.pop_front();
      if (e.epoch == epoch && !redir) fifo_q.push_back('{e.addr, e.addr ^ KEY});
    end
    if (grant) begin
      mem_q.push_back('{m_pc, epoch, cyc + $urandom_range(lat_hi, lat_lo)});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      fifo_q.delete();
      epoch++;
      m_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic g, input logic r);
    for (int i = 0; i < n; i++) cycle(g, r, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    lat_lo  = 1;
    lat_hi  = 1;
    rst_i   = 1'b0;
    drive_idle();
    model_reset();
    do_reset();

    // Streaming: one instruction per cycle with 1-cycle memory.
    run(20, 1'b1, 1'b1);

    // Backpressure: decode stalled, requests stop at DEPTH, resume after a pop.
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    run(10, 1'b1, 1'b0);
    run(8, 1'b1, 1'b1);

    // Redirect with two in flight plus a grant in the redirect cycle (3-cycle memory).
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    run(6, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    run(12, 1'b1, 1'b1);

    // Redirect alignment and address wrap.
    lat_lo = 1;
    lat_hi = 1;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run(6, 1'b1, 1'b1);

    // Full FIFO with pop, stray rvalid and redirect together.
    cycle(1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    run(8, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    run(1, 1'b0, 1'b0);

    // Nearly full FIFO with a real response, pop and redirect together.
    lat_lo = 2;
    lat_hi = 2;
    run(5, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
    run(8, 1'b1, 1'b1);

    // Randomized traffic with variable latency, redirects and stray rvalids.
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset in the middle of streaming, then restart from RESET_PC.
    lat_lo = 1;
    lat_hi = 1;
    run(5, 1'b1, 1'b1);
    do_reset();
    run(12, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
